// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin arbiter mux: index width and lock-state type.
package arb_pkg;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        LockIdle,
        LockHeld
    } lock_st_e;

endpackage

// File: rtl/mux_pry_tree.sv
// One-hot select mux built as an AND-OR reduction tree with a configurable split factor.
module mux_pry_tree #(
    parameter type         DAT_T = logic [8-1:0],
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SPLIT = 2
) (
    input  logic [WIDTH-1:0] pry,
    input  DAT_T             din [WIDTH],
    output DAT_T             dout
);
    localparam int unsigned DW = $bits(DAT_T);

    always_comb begin
        logic [DW-1:0] lvl [WIDTH];
        logic [DW-1:0] acc;
        int unsigned   n;
        int unsigned   m;
        acc = '0;
        n   = WIDTH;
        m   = WIDTH;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            lvl[i] = pry[i] ? din[i] : '0;
        end
        // Each pass folds groups of SPLIT nodes in place; node j only reads nodes >= j.
        for (int unsigned lv = 0; lv < WIDTH; lv++) begin
            if (n > 1) begin
                m = (n + SPLIT - 1) / SPLIT;
                for (int unsigned j = 0; j < WIDTH; j++) begin
                    if (j < m) begin
                        acc = '0;
                        for (int unsigned k = 0; k < SPLIT; k++) begin
                            if (j * SPLIT + k < n) begin
                                acc = acc | lvl[j * SPLIT + k];
                            end
                        end
                        lvl[j] = acc;
                    end
                end
                n = m;
            end
        end
        dout = lvl[0];
    end

endmodule

// File: rtl/arb_rr_mux.sv
// Round-robin arbiter feeding a one-deep registered output stage.
// Optional packet locking (req_lst/out_lst) is enabled with ARB_RR_LOCK_EN.
module arb_rr_mux
    import arb_pkg::*;
#(
    parameter type         DAT_T = logic [8-1:0],
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SPLIT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         req_vld,
    input  DAT_T                     req_dat [WIDTH],
    output logic [WIDTH-1:0]         req_rdy,
`ifdef ARB_RR_LOCK_EN
    input  logic [WIDTH-1:0]         req_lst,
    output logic                     out_lst,
`endif
    output logic                     out_vld,
    input  logic                     out_rdy,
    output DAT_T                     out_dat,
    output logic [$clog2(WIDTH)-1:0] out_idx
);
    localparam int unsigned IW = idx_w(WIDTH);

    logic [IW-1:0]    ptr_q;
    logic [WIDTH-1:0] elig;
    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] pick;
    logic [WIDTH-1:0] gnt_oh;
    logic [IW-1:0]    gnt_idx;
    logic             ld;
    logic             xfer;
    DAT_T             sel_dat;

`ifdef ARB_RR_LOCK_EN
    lock_st_e      lock_q;
    logic [IW-1:0] lock_idx_q;
`endif

    always_comb begin
`ifdef ARB_RR_LOCK_EN
        elig = (lock_q == LockHeld) ? (req_vld & (WIDTH'(1) << lock_idx_q)) : req_vld;
`else
        elig = req_vld;
`endif
        // Prefer requesters at or above ptr; fall back to the full set to wrap around.
        lo_mask = (WIDTH'(1) << ptr_q) - WIDTH'(1);
        high    = elig & ~lo_mask;
        pick    = (|high) ? high : elig;
        gnt_oh  = pick & (~pick + WIDTH'(1));
        gnt_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (gnt_oh[i]) begin
                gnt_idx = IW'(i);
            end
        end
        ld      = !out_vld || out_rdy;
        req_rdy = rst ? '0 : (gnt_oh & {WIDTH{ld}});
        xfer    = |req_rdy;
    end

    mux_pry_tree #(
        .DAT_T(DAT_T),
        .WIDTH(WIDTH),
        .SPLIT(SPLIT)
    ) u_mux (
        .pry (gnt_oh),
        .din (req_dat),
        .dout(sel_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld    <= 1'b0;
            out_dat    <= '0;
            out_idx    <= '0;
            ptr_q      <= '0;
`ifdef ARB_RR_LOCK_EN
            out_lst    <= 1'b0;
            lock_q     <= LockIdle;
            lock_idx_q <= '0;
`endif
        end else begin
            if (ld) begin
                out_vld <= xfer;
            end
            if (xfer) begin
                out_dat <= sel_dat;
                out_idx <= gnt_idx;
                ptr_q   <= gnt_idx + IW'(1);
`ifdef ARB_RR_LOCK_EN
                out_lst    <= req_lst[gnt_idx];
                lock_q     <= req_lst[gnt_idx] ? LockIdle : LockHeld;
                lock_idx_q <= gnt_idx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_arb_rr_mux.sv
// Bench for arb_rr_mux: directed vector table, reset corner cases and randomized model check.
module tb_arb_rr_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_vld;
    logic [7:0] req_dat [4];
    logic [3:0] req_rdy;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] out_dat;
    logic [1:0] out_idx;
`ifdef ARB_RR_LOCK_EN
    logic [3:0] req_lst = 4'hF;
    logic       out_lst;
`endif

    arb_rr_mux #(
        .DAT_T(logic [7:0]),
        .WIDTH(4),
        .SPLIT(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_vld(req_vld),
        .req_dat(req_dat),
        .req_rdy(req_rdy),
`ifdef ARB_RR_LOCK_EN
        .req_lst(req_lst),
        .out_lst(out_lst),
`endif
        .out_vld(out_vld),
        .out_rdy(out_rdy),
        .out_dat(out_dat),
        .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      vld;
        logic [3:0][7:0] dat;
        logic            ordy;
        logic [3:0]      e_rdy;
        logic            e_vld;
        logic [1:0]      e_idx;
        logic [7:0]      e_dat;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int         m_ptr;
    bit         m_vld;
    logic [7:0] m_dat;
    int         m_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0][7:0] d, input logic ordy);
        req_vld = v;
        out_rdy = ordy;
        for (int i = 0; i < 4; i++) req_dat[i] = d[i];
    endtask

    // Called at posedge+1; leaves time at the next posedge+1.
    task automatic dstep(input string name, input vec_t t);
        drive(t.vld, t.dat, t.ordy);
        @(negedge clk);
        check({name, "_rdy"}, 32'(req_rdy), 32'(t.e_rdy));
        @(posedge clk);
        #1;
        check({name, "_vld"}, 32'(out_vld), 32'(t.e_vld));
        check({name, "_idx"}, 32'(out_idx), 32'(t.e_idx));
        check({name, "_dat"}, 32'(out_dat), 32'(t.e_dat));
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_vld = 0;
        m_dat = '0;
        m_idx = 0;
    endtask

    task automatic mstep(input logic [3:0] v, input logic [3:0][7:0] d, input logic ordy);
        bit         ld;
        int         g;
        logic [3:0] e_rdy;
        ld = !m_vld || ordy;
        g  = -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (g < 0 && v[i]) g = i;
        end
        e_rdy = (ld && g >= 0) ? (4'b0001 << g) : 4'b0000;
        drive(v, d, ordy);
        @(negedge clk);
        check("rnd_rdy", 32'(req_rdy), 32'(e_rdy));
        @(posedge clk);
        #1;
        if (ld) begin
            if (g >= 0) begin
                m_vld = 1;
                m_dat = d[g];
                m_idx = g;
                m_ptr = (g + 1) % 4;
            end else begin
                m_vld = 0;
            end
        end
        check("rnd_vld", 32'(out_vld), 32'(m_vld));
        if (m_vld) begin
            check("rnd_idx", 32'(out_idx), 32'(m_idx));
            check("rnd_dat", 32'(out_dat), 32'(m_dat));
        end
    endtask

    initial begin
        logic [3:0][7:0] dd;
        logic [3:0][7:0] da;
        vec_t            tbl [16];
        logic [3:0][7:0] rd;

        dd = {8'h13, 8'h12, 8'h11, 8'h10};
        da = {8'h13, 8'hA5, 8'h11, 8'h10};
        tbl[0]  = '{4'b1111, dd, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tbl[1]  = '{4'b1111, dd, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        tbl[2]  = '{4'b1111, dd, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        tbl[3]  = '{4'b1111, dd, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
        tbl[4]  = '{4'b1111, dd, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tbl[5]  = '{4'b0100, dd, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        tbl[6]  = '{4'b0011, dd, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tbl[7]  = '{4'b0011, dd, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        tbl[8]  = '{4'b0000, dd, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11};
        tbl[9]  = '{4'b1111, dd, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        tbl[10] = '{4'b0100, da, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        tbl[11] = '{4'b0100, da, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5};
        tbl[12] = '{4'b0100, da, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5};
        tbl[13] = '{4'b0100, da, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5};
        tbl[14] = '{4'b0100, da, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        tbl[15] = '{4'b0000, da, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA5};

        // Reset state, with requests pending to show req_rdy is forced low.
        rst = 1'b1;
        drive(4'b1111, dd, 1'b1);
        #3;
        check("rst_rdy", 32'(req_rdy), 32'h0);
        check("rst_vld", 32'(out_vld), 32'h0);
        check("rst_dat", 32'(out_dat), 32'h0);
        check("rst_idx", 32'(out_idx), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(4'b0000, dd, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) dstep($sformatf("vec%0d", i), tbl[i]);

        // Reset mid-operation: load a beat, stall it, then pulse rst between edges.
        dstep("pre_rst", '{4'b1111, dd, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h13});
        #2;
        rst = 1'b1;
        #1;
        check("arst_vld", 32'(out_vld), 32'h0);
        check("arst_rdy", 32'(req_rdy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        mstep(4'b1111, dd, 1'b1);
        check("rst_regrant", 32'(out_idx), 32'h0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) rd[i] = 8'($urandom_range(0, 255));
            mstep(4'($urandom_range(0, 15)), rd, ($urandom_range(0, 3) != 0));
        end

`ifdef ARB_RR_LOCK_EN
        // Requester 1 holds a three-beat packet while requester 2 waits.
        drive(4'b0000, dd, 1'b1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        req_lst = 4'b0100;
        dstep("lock0", '{4'b0110, dd, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11});
        check("lock0_lst", 32'(out_lst), 32'h0);
        dstep("lock1", '{4'b0110, dd, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11});
        check("lock1_lst", 32'(out_lst), 32'h0);
        req_lst = 4'b0110;
        dstep("lock2", '{4'b0110, dd, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11});
        check("lock2_lst", 32'(out_lst), 32'h1);
        dstep("lock3", '{4'b0110, dd, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12});
        check("lock3_lst", 32'(out_lst), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
